// File: rtl/stitch_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// stitch_pipe_ctrl
//
// Valid/ready flow controller for a stitched pipeline of combinational stage
// modules separated by plain data registers. It keeps one valid bit per
// register stage and produces the per-stage load enables. With these enables
// the data-only pipeline gets backpressure, bubble collapsing and flush.
// Data register N of the stitched wrapper loads on stage_en[N].
//
// Handshake semantics: a transfer happens on a rising clk edge where both
// valid and ready are high. in_valid/in_ready cover entry into stage 0, and
// out_valid/out_ready cover exit from the last stage. An offered item is held
// stable by its producer until the transfer happens. in_ready depends
// combinationally on out_ready through the ready chain; there is no skid
// buffer.
//
// Parameters:
//   STAGES  number of register stages (1..8)
//   CNT_W   stall counter width
//   OCC_W   occupancy width, derived from STAGES (do not override)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid     upstream offers an item
//   in_ready     stage 0 accepts an item this cycle
//   out_valid    last stage holds a valid item
//   out_ready    downstream consumes the item
//   flush        discard all in-flight items
//   stage_en     per-stage data register load enable
//   stage_valid  per-stage registered valid bit
//   occupancy    number of valid stages
//   busy         occupancy != 0
//   stall_count  cycles with out_valid & ~out_ready, saturating
//
// Configuration macro: STITCH_PIPE_CTRL_STALL_CNT_EN
//   Defined:   stall_count is a saturating counter that only reset clears.
//   Undefined: stall_count is tied to zero and has no flops.
// -----------------------------------------------------------------------------
module stitch_pipe_ctrl #(
  parameter int STAGES = 2,
  parameter int CNT_W  = 16,
  parameter int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              flush,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_valid,
  output logic [OCC_W-1:0]  occupancy,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_count
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] up;
  logic [OCC_W-1:0]  occ;
  logic              fire_in;
  logic              fire_out;
  logic              pass;
  logic              room;

  // rdy[i] = ~v[i] | rdy[i+1], and the last stage is ready when out_ready is
  // high. Unrolled, this means stage i is ready when out_ready is high or
  // any stage at or after i is empty. Building it with a running OR keeps
  // the vector free of self-reference.
  always_comb begin
    rdy  = '0;
    up   = '0;
    room = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      room   = room | ~v[i];
      rdy[i] = room;
    end
    up[0] = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      up[i] = v[i-1];
    end
  end

  // Flush and reset both block every transfer and every load.
  assign pass      = ~flush & rst_n;
  assign stage_en  = rdy & up & {STAGES{pass}};
  assign in_ready  = rdy[0] & pass;
  assign out_valid = v[STAGES-1] & pass;
  assign fire_in   = in_valid & in_ready;
  assign fire_out  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v   <= '0;
      occ <= '0;
    end else if (flush) begin
      v   <= '0;
      occ <= '0;
    end else begin
      // A ready stage takes whatever sits upstream, including a bubble.
      // Because of this, empty stages fill even while the output is stalled.
      for (int i = 0; i < STAGES; i++) begin
        if (rdy[i]) begin
          v[i] <= up[i];
        end
      end
      case ({fire_in, fire_out})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign stage_valid = v;
  assign occupancy   = occ;
  assign busy        = (occ != '0);

`ifdef STITCH_PIPE_CTRL_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Flush does not clear the counter; it only saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && !(&stall_q)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_stitch_pipe_ctrl.sv
module tb_stitch_pipe_ctrl;

  localparam int S  = 3;
  localparam int CW = 4;
  localparam int OW = $clog2(S + 1);
  localparam int W  = 8;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [S-1:0]  stage_en;
  logic [S-1:0]  stage_valid;
  logic [OW-1:0] occupancy;
  logic          busy;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  stitch_pipe_ctrl #(.STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .stage_en(stage_en), .stage_valid(stage_valid), .occupancy(occupancy),
    .busy(busy), .stall_count(stall_count)
  );

  // Stand-in stitched datapath: plain registers loaded by stage_en.
  logic [W-1:0] in_data = '0;
  logic [W-1:0] data_r [S];

  always @(posedge clk) begin
    if (stage_en[0]) data_r[0] <= in_data;
    for (int i = 1; i < S; i++) begin
      if (stage_en[i]) data_r[i] <= data_r[i-1];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // In-flight items oldest first, each with the stage it sits in.
  // Items move one stage forward whenever the slot ahead is free or is being
  // vacated, and the oldest item leaves from the last stage on a handshake.
  int           pos_q[$];
  int           nxt_pos[$];
  logic [W-1:0] exp_q[$];
  int           stall_m = 0;
  bit           armed = 1'b0;
  bit           fin_s, flush_s, stall_inc_s;
  logic [W-1:0] tok_s;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs at the falling edge, pops the scoreboard
  // on each output handshake, and prepares the model's next state.
  always @(negedge clk) begin
    bit           exp_ir, exp_ov, fin, fout;
    logic [S-1:0] exp_sv, exp_en;
    int           lim, p;
    if (armed) begin
      exp_sv = '0;
      foreach (pos_q[k]) exp_sv[pos_q[k]] = 1'b1;
      exp_ir = rst_n && !flush && ((pos_q.size() < S) || out_ready);
      exp_ov = rst_n && !flush && (pos_q.size() > 0) && (pos_q[0] == S - 1);
      fin  = in_valid && exp_ir;
      fout = exp_ov && out_ready;

      nxt_pos = {};
      exp_en  = '0;
      lim     = S;
      if (rst_n && !flush) begin
        for (int k = (fout ? 1 : 0); k < pos_q.size(); k++) begin
          p = pos_q[k];
          if (p + 1 < lim) begin
            p = p + 1;
            exp_en[p] = 1'b1;
          end
          nxt_pos.push_back(p);
          lim = p;
        end
        if (fin) begin
          nxt_pos.push_back(0);
          exp_en[0] = 1'b1;
        end
      end

      chk("in_ready",    int'(in_ready),    int'(exp_ir));
      chk("out_valid",   int'(out_valid),   int'(exp_ov));
      chk("stage_valid", int'(stage_valid), int'(exp_sv));
      chk("stage_en",    int'(stage_en),    int'(exp_en));
      chk("occupancy",   int'(occupancy),   pos_q.size());
      chk("busy",        int'(busy),        int'(pos_q.size() != 0));
      chk("stall_count", int'(stall_count), stall_m);

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_data at %0t: output with empty expected queue, got %0d", $time, data_r[S-1]);
        end else begin
          chk("out_data", int'(data_r[S-1]), int'(exp_q.pop_front()));
        end
      end

      fin_s       = fin;
      tok_s       = in_data;
      flush_s     = flush;
      stall_inc_s = exp_ov && !out_ready;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      pos_q   = {};
      exp_q   = {};
      stall_m = 0;
      armed   = 1'b1;
    end else if (armed) begin
      pos_q = nxt_pos;
      if (flush_s) exp_q = {};
      if (fin_s) exp_q.push_back(tok_s);
`ifdef STITCH_PIPE_CTRL_STALL_CNT_EN
      if (stall_inc_s && stall_m < (1 << CW) - 1) stall_m++;
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input bit iv, input bit ordy, input bit fl, input bit rn, input int n);
    for (int c = 0; c < n; c++) begin
      in_valid  = iv;
      out_ready = ordy;
      flush     = fl;
      rst_n     = rn;
      in_data   = W'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // streaming at full rate
    cyc(1, 1, 0, 1, 5);
    cyc(0, 1, 0, 1, 4);
    // fill while stalled, then stream through a full pipe, then drain
    cyc(1, 0, 0, 1, 6);
    cyc(1, 1, 0, 1, 5);
    cyc(0, 1, 0, 1, 4);
    // single item collapses to the last stage under stall
    cyc(1, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 3);
    cyc(0, 1, 0, 1, 3);
    // flush a full, stalled pipeline
    cyc(1, 0, 0, 1, 4);
    cyc(1, 0, 1, 1, 1);
    cyc(0, 0, 0, 1, 2);
    // reset mid-stream
    cyc(1, 1, 0, 1, 4);
    cyc(1, 1, 0, 0, 2);
    cyc(0, 1, 0, 1, 3);
    // long stall drives the counter into saturation
    cyc(1, 0, 0, 1, (1 << CW) + 5);
    cyc(0, 1, 0, 1, 5);
    // randomized traffic
    for (int r = 0; r < 2000; r++) begin
      cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
          bit'($urandom_range(0, 31) == 0), bit'($urandom_range(0, 199) != 0), 1);
    end
    cyc(0, 1, 0, 1, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
